// File: rtl/addsub_30_pipe.sv
// addsub_30_pipe: pipelined two's-complement adder/subtractor.
// The carry chain is cut into SEG-bit segments with one register stage per
// segment. Each stage resolves its own segment, appends it to the partial
// sum from the stage below, and forwards only the operand bits that later
// stages still need (the operand MSBs always travel, since they feed the
// overflow flag). Operands and results use valid/ready handshakes, and a
// combinational ready chain gives full throughput with no bubbles.
module addsub_30_pipe #(
  parameter int WIDTH = 30,
  parameter int SEG   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] C,
  output logic             cout,
  output logic             borrow,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NS = WIDTH / SEG;

  for (genvar gi = 0; gi < NS; gi++) begin : g_stage
    // Lowest bit resolved by this stage.
    localparam int LO   = gi * SEG;
    // Lowest operand bit still needed downstream. The last stage keeps only
    // the MSBs, which it needs for the overflow flag.
    localparam int KEEP = (gi == NS - 1) ? (WIDTH - 1) : ((gi + 1) * SEG);

    // Stage registers.
    logic                  v_reg;
    logic [WIDTH-1:KEEP]   a_reg;
    logic [WIDTH-1:KEEP]   b_reg;
    logic [LO+SEG-1:0]     sum_reg;
    logic                  carry_reg;
    logic                  sub_reg;

    // Values presented to this stage by the one below (or by the input port).
    logic                  v_in;
    logic [WIDTH-1:LO]     a_in;
    logic [WIDTH-1:LO]     b_in;
    logic                  carry_in;
    logic                  sub_in;
    logic [SEG:0]          seg_sum;
    logic [LO+SEG-1:0]     sum_next;
    logic                  ready;

    if (gi == 0) begin : g_head
      // The first stage inverts B for subtraction and injects sub as carry-in,
      // so A - B becomes A + ~B + 1.
      assign v_in     = in_valid;
      assign a_in     = A;
      assign b_in     = sub ? ~B : B;
      assign carry_in = sub;
      assign sub_in   = sub;
      assign sum_next = seg_sum[SEG-1:0];
    end else begin : g_body
      // Later stages consume the registered carry and the operand bits that
      // the previous stage carried forward.
      assign v_in     = g_stage[gi-1].v_reg;
      assign a_in     = g_stage[gi-1].a_reg;
      assign b_in     = g_stage[gi-1].b_reg;
      assign carry_in = g_stage[gi-1].carry_reg;
      assign sub_in   = g_stage[gi-1].sub_reg;
      assign sum_next = {seg_sum[SEG-1:0], g_stage[gi-1].sum_reg};
    end

    if (gi == NS - 1) begin : g_tail
      // The output stage can move whenever it is empty or being drained.
      assign ready = !v_reg || out_ready;
    end else begin : g_mid
      // A stage can move whenever it is empty or the stage above can move.
      assign ready = !v_reg || g_stage[gi+1].ready;
    end

    // SEG-bit segment add with the carry from the segment below.
    always_comb begin
      seg_sum = {1'b0, a_in[LO +: SEG]} + {1'b0, b_in[LO +: SEG]}
              + {{SEG{1'b0}}, carry_in};
    end

    // Stage register: advances when ready; data loads only for valid
    // transactions so the output stage never shows stale operands.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg <= 1'b0;
        if (gi == NS - 1) begin
          a_reg     <= '0;
          b_reg     <= '0;
          sum_reg   <= '0;
          carry_reg <= 1'b0;
          sub_reg   <= 1'b0;
        end
      end else if (ready) begin
        v_reg <= v_in;
        if (v_in) begin
          a_reg     <= a_in[WIDTH-1:KEEP];
          b_reg     <= b_in[WIDTH-1:KEEP];
          sum_reg   <= sum_next;
          carry_reg <= seg_sum[SEG];
          sub_reg   <= sub_in;
        end
      end
    end
  end

  // Nothing is accepted while reset is held.
  assign in_ready  = !rst && g_stage[0].ready;

  assign out_valid = g_stage[NS-1].v_reg;
  assign C         = g_stage[NS-1].sum_reg;
  assign cout      = g_stage[NS-1].carry_reg;
  // For subtraction a missing carry-out means the unsigned result borrowed.
  assign borrow    = g_stage[NS-1].sub_reg && !g_stage[NS-1].carry_reg;
  // Overflow: both addends share a sign and the result's sign differs.
  assign ovf       = (g_stage[NS-1].a_reg[WIDTH-1] == g_stage[NS-1].b_reg[WIDTH-1])
                  && (C[WIDTH-1] != g_stage[NS-1].a_reg[WIDTH-1]);

endmodule
